// File: rtl/avalon_matrix_loader_pkg.sv
// Shared types and helpers for the Avalon-MM matrix/vector loader.
package avalon_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned SEL_MAX_BUS_W  = 32'd1024;
  localparam int unsigned SEL_MAX_ELEM_W = 32'd64;

  // Element idx of a word holding n elements of elem_w bits; msb_first puts element 0 at the top.
  function automatic logic [SEL_MAX_ELEM_W-1:0] sel_elem(
    input logic [SEL_MAX_BUS_W-1:0] word,
    input int unsigned              idx,
    input int unsigned              n,
    input int unsigned              elem_w,
    input logic                     msb_first
  );
    int unsigned shift;
    shift = msb_first ? (n - 32'd1 - idx) * elem_w : idx * elem_w;
    return SEL_MAX_ELEM_W'(word >> shift);
  endfunction

endpackage

// File: rtl/avalon_matrix_loader_if.sv
// Avalon-MM read-only bus between the loader (master) and memory (slave).
interface avalon_matrix_loader_if #(
  parameter int unsigned BUS_W = 32'd64
);
  logic [31:0]      avm_address;
  logic             avm_read;
  logic [BUS_W-1:0] avm_readdata;
  logic             avm_readdatavalid;
  logic             avm_waitrequest;

  modport master (
    output avm_address, avm_read,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/avalon_matrix_loader_row_fifo.sv
// Small synchronous FIFO holding returned row words until they are unpacked.
module loader_row_fifo #(
  parameter int unsigned W     = 32'd64,
  parameter int unsigned DEPTH = 32'd2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 32'd1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Storage array, written only on push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; the caller never pushes when full or pops when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 32'd1)) ? '0 : wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 32'd1)) ? '0 : rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/avalon_matrix_loader.sv
// Avalon-MM read master: fetches N matrix rows plus one vector row and unpacks
// them element by element into the per-row A FIFOs and the B FIFO.
module avalon_matrix_loader
  import avalon_loader_pkg::*;
#(
  parameter int unsigned N           = 32'd8,
  parameter int unsigned ELEM_W      = 32'd8,
  parameter int unsigned BASE_ADDR   = 32'd0,
  parameter int unsigned ADDR_STRIDE = 32'd1,
  parameter int unsigned DEPTH       = 32'd2,
  parameter int unsigned MSB_FIRST   = 32'd1,
  parameter int unsigned AUTO_START  = 32'd0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  avalon_matrix_loader_if.master    avm,
  output logic [N-1:0]              a_wren,
  output logic [N*ELEM_W-1:0]       a_data,
  input  logic [N-1:0]              a_full,
  output logic                      b_wren,
  output logic [ELEM_W-1:0]         b_data,
  input  logic                      b_full,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [$clog2(N+1)-1:0]    dbg_row,
  output logic [$clog2(N)-1:0]      dbg_elem
);

  localparam int unsigned BUS_W   = N * ELEM_W;
  localparam int unsigned ROW_W   = $clog2(N + 32'd1);
  localparam int unsigned EIDX_W  = $clog2(N);
  localparam int unsigned ISSUE_W = $clog2(N + 32'd2);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 32'd1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  state_t              state_r;
  logic [ISSUE_W-1:0]  issue_row_r;
  logic [ROW_W-1:0]    drain_row_r;
  logic [EIDX_W-1:0]   drain_elem_r;
  logic [CNT_W-1:0]    outstanding_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;
  logic                auto_r;

  logic [CNT_W-1:0]          fifo_count_s;
  logic [BUS_W-1:0]          head_s;
  logic                      head_valid_s;
  logic                      read_s;
  logic                      accept_s;
  logic                      push_s;
  logic                      pop_s;
  logic                      spurious_s;
  logic                      wr_s;
  logic                      last_elem_s;
  logic                      start_eff_s;
  logic [SEL_MAX_ELEM_W-1:0] elem_full_s;
  logic [ELEM_W-1:0]         elem_s;
  logic [N-1:0]              a_wren_s;
  logic [N*ELEM_W-1:0]       a_data_s;
  logic                      b_wren_s;
  logic [ELEM_W-1:0]         b_data_s;

  // Reads in flight plus rows already buffered never exceed DEPTH, so a return always has a slot.
  assign read_s = (state_r == ST_RUN) && (issue_row_r <= ISSUE_W'(N)) &&
                  (({1'b0, outstanding_r} + {1'b0, fifo_count_s}) < DEPTH_C);
  assign avm.avm_read    = read_s;
  assign avm.avm_address = read_s ? (32'(BASE_ADDR) + 32'(issue_row_r) * 32'(ADDR_STRIDE)) : 32'd0;

  assign accept_s     = read_s && !avm.avm_waitrequest;
  assign push_s       = avm.avm_readdatavalid && (outstanding_r != '0);
  assign spurious_s   = avm.avm_readdatavalid && (outstanding_r == '0);
  assign head_valid_s = (fifo_count_s != '0);
  assign last_elem_s  = (drain_elem_r == EIDX_W'(N - 32'd1));
  assign pop_s        = wr_s && last_elem_s;
  assign start_eff_s  = start || auto_r;
  assign elem_full_s  = sel_elem(SEL_MAX_BUS_W'(head_s), 32'(drain_elem_r), N, ELEM_W, 1'(MSB_FIRST));
  assign elem_s       = elem_full_s[ELEM_W-1:0];

  loader_row_fifo #(
    .W     (BUS_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_row_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (avm.avm_readdata),
    .pop   (pop_s),
    .rdata (head_s),
    .count (fifo_count_s)
  );

  // Drain steering: the full flag gates the write in the same cycle.
  always_comb begin
    a_wren_s = '0;
    a_data_s = '0;
    b_wren_s = 1'b0;
    b_data_s = '0;
    wr_s     = 1'b0;
    if ((state_r == ST_RUN) && head_valid_s) begin
      if (drain_row_r == ROW_W'(N)) begin
        b_wren_s = !b_full;
        b_data_s = elem_s;
        wr_s     = !b_full;
      end else begin
        for (int r = 0; r < N; r++) begin
          if (drain_row_r == ROW_W'(r)) begin
            a_wren_s[r]                  = !a_full[r];
            a_data_s[r*ELEM_W +: ELEM_W] = elem_s;
            wr_s                         = !a_full[r];
          end else begin
            a_wren_s[r] = 1'b0;
          end
        end
      end
    end else begin
      wr_s = 1'b0;
    end
  end

  // Control FSM with issue, return and drain bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      issue_row_r   <= '0;
      drain_row_r   <= '0;
      drain_elem_r  <= '0;
      outstanding_r <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      auto_r        <= 1'(AUTO_START);
    end else begin
      auto_r <= 1'b0;
      if (spurious_s) begin
        err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_eff_s) begin
            state_r       <= ST_RUN;
            issue_row_r   <= '0;
            drain_row_r   <= '0;
            drain_elem_r  <= '0;
            outstanding_r <= '0;
            busy_r        <= 1'b1;
            done_r        <= 1'b0;
            err_r         <= spurious_s;
          end
        end
        ST_RUN: begin
          outstanding_r <= outstanding_r + CNT_W'(accept_s) - CNT_W'(push_s);
          if (accept_s) begin
            issue_row_r <= issue_row_r + ISSUE_W'(1);
          end
          if (wr_s) begin
            if (last_elem_s) begin
              drain_elem_r <= '0;
              if (drain_row_r == ROW_W'(N)) begin
                state_r <= ST_DONE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end else begin
                drain_row_r <= drain_row_r + ROW_W'(1);
              end
            end else begin
              drain_elem_r <= drain_elem_r + EIDX_W'(1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_wren   = a_wren_s;
  assign a_data   = a_data_s;
  assign b_wren   = b_wren_s;
  assign b_data   = b_data_s;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign dbg_row  = drain_row_r;
  assign dbg_elem = drain_elem_r;

endmodule

// File: tb/tb_avalon_matrix_loader.sv
// Directed bench: dut1 (DEPTH 2, zero-wait slave with optional stall) and
// dut2 (DEPTH 4, AUTO_START, 4-cycle-latency slave).
module tb_avalon_matrix_loader;

  localparam int N  = 8;
  localparam int EW = 8;
  localparam int BW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int ntotal = 0;
  int nbad   = 0;

  logic          start1 = 1'b0;
  logic          start2 = 1'b0;
  logic [N-1:0]  a_full1 = '0;
  logic [N-1:0]  a_full2 = '0;
  logic          b_full1 = 1'b0;
  logic          b_full2 = 1'b0;
  logic [N-1:0]  a_wren1, a_wren2;
  logic [BW-1:0] a_data1, a_data2;
  logic          b_wren1, b_wren2;
  logic [EW-1:0] b_data1, b_data2;
  logic          busy1, busy2, done1, done2, err1, err2;
  logic [3:0]    dbg_row1, dbg_row2;
  logic [2:0]    dbg_elem1, dbg_elem2;

  avalon_matrix_loader_if #(.BUS_W(BW)) avm1 ();
  avalon_matrix_loader_if #(.BUS_W(BW)) avm2 ();

  avalon_matrix_loader #(.N(8), .ELEM_W(8), .DEPTH(2), .MSB_FIRST(1), .AUTO_START(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .avm(avm1),
    .a_wren(a_wren1), .a_data(a_data1), .a_full(a_full1),
    .b_wren(b_wren1), .b_data(b_data1), .b_full(b_full1),
    .busy(busy1), .done(done1), .err(err1), .dbg_row(dbg_row1), .dbg_elem(dbg_elem1));

  avalon_matrix_loader #(.N(8), .ELEM_W(8), .DEPTH(4), .MSB_FIRST(1), .AUTO_START(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .avm(avm2),
    .a_wren(a_wren2), .a_data(a_data2), .a_full(a_full2),
    .b_wren(b_wren2), .b_data(b_data2), .b_full(b_full2),
    .busy(busy2), .done(done2), .err(err2), .dbg_row(dbg_row2), .dbg_elem(dbg_elem2));

  // Memory image: row r holds bytes r*8+1 .. r*8+8, first byte in the top lane.
  function automatic logic [63:0] mem_word(input logic [31:0] addr);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[63-8*k -: 8] = 8'(addr * 32'd8 + 32'd1 + 32'(k));
    return w;
  endfunction

  // Slave 1: zero-wait, one-cycle latency; optional 3-cycle stall on address 2.
  logic        wait_en = 1'b0;
  int          wait_cnt = 0;
  logic        spur1 = 1'b0;
  logic        rdv1_r = 1'b0;
  logic [63:0] rd1_r = '0;
  assign avm1.avm_waitrequest   = wait_en && avm1.avm_read && (avm1.avm_address == 32'd2) && (wait_cnt < 3);
  assign avm1.avm_readdatavalid = rdv1_r | spur1;
  assign avm1.avm_readdata      = rd1_r;
  always @(posedge clk) begin
    rdv1_r <= avm1.avm_read && !avm1.avm_waitrequest;
    rd1_r  <= mem_word(avm1.avm_address);
    if (!wait_en) wait_cnt <= 0;
    else if (avm1.avm_waitrequest) wait_cnt <= wait_cnt + 1;
  end

  // Slave 2: never stalls, four-cycle read latency.
  logic [3:0]  pipe2 = '0;
  logic [31:0] ap2 [4];
  assign avm2.avm_waitrequest   = 1'b0;
  assign avm2.avm_readdatavalid = pipe2[3];
  assign avm2.avm_readdata      = mem_word(ap2[3]);
  always @(posedge clk) begin
    pipe2  <= {pipe2[2:0], avm2.avm_read};
    ap2[0] <= avm2.avm_address;
    for (int i = 1; i < 4; i++) ap2[i] <= ap2[i-1];
  end

  // Monitor: logs FIFO writes as {row, data} and tracks dut2's reads in flight.
  logic [15:0] wlog[$];
  logic [7:0]  blog2[$];
  int pulses1 = 0, pulses2 = 0, rd2_cycles = 0, os2 = 0, max_os2 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      os2 = 0;
      max_os2 = 0;
    end else begin
      for (int r = 0; r < N; r++) begin
        if (a_wren1[r]) begin
          wlog.push_back({8'(r), a_data1[r*EW +: EW]});
          pulses1++;
        end
        if (a_wren2[r]) pulses2++;
      end
      if (b_wren1) begin
        wlog.push_back({8'd8, b_data1});
        pulses1++;
      end
      if (b_wren2) begin
        blog2.push_back(b_data2);
        pulses2++;
      end
      if (avm1.avm_read && avm1.avm_address == 32'd2) rd2_cycles++;
      if (avm2.avm_read) os2++;
      if (avm2.avm_readdatavalid && os2 > 0) os2--;
      if (os2 > max_os2) max_os2 = os2;
    end
  end

  // Number of in-order correct elements for row r logged since base; -1 on a wrong value.
  function automatic int row_count(input int base, input int r);
    int idx = 0;
    for (int i = base; i < wlog.size(); i++) begin
      if (wlog[i][15:8] == 8'(r)) begin
        if (wlog[i][7:0] != 8'(r * 8 + 1 + idx)) return -1;
        idx++;
      end
    end
    return idx;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
  endtask

  task automatic wait_done1(input int limit);
    for (int c = 0; c < limit && done1 !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [BW+EW+N+32+13:0] out1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out1 = {busy1, done1, err1, avm1.avm_read, avm1.avm_address, a_wren1, a_data1,
            b_wren1, b_data1, dbg_row1, dbg_elem1};
    ntotal++;
    if (out1 !== '0) begin
      nbad++;
      $display("FAIL reset_outputs1: got %h expected 0", out1);
    end
    ntotal++;
    if ({busy2, done2, err2, avm2.avm_read, a_wren2, b_wren2} !== '0) begin
      nbad++;
      $display("FAIL reset_outputs2: got %b expected 0", {busy2, done2, err2, avm2.avm_read, a_wren2, b_wren2});
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_spurious();
    @(posedge clk); #1;
    ntotal++;
    if (err1 !== 1'b0) begin
      nbad++;
      $display("FAIL err_before_spurious: got %b expected 0", err1);
    end
    spur1 = 1'b1;
    @(posedge clk); #1 spur1 = 1'b0;
    ntotal++;
    if (err1 !== 1'b1) begin
      nbad++;
      $display("FAIL err_after_spurious: got %b expected 1", err1);
    end
    ntotal++;
    if (busy1 !== 1'b0) begin
      nbad++;
      $display("FAIL idle_busy: got %b expected 0", busy1);
    end
  endtask

  task automatic test_auto_depth4();
    int bad_b = 0;
    for (int c = 0; c < 400 && done2 !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    ntotal++;
    if (done2 !== 1'b1 || busy2 !== 1'b0) begin
      nbad++;
      $display("FAIL auto_done: got done=%b busy=%b expected done=1 busy=0", done2, busy2);
    end
    ntotal++;
    if (pulses2 != 72) begin
      nbad++;
      $display("FAIL auto_pulses: got %0d expected 72", pulses2);
    end
    for (int i = 0; i < blog2.size(); i++) if (blog2[i] != 8'(65 + i)) bad_b++;
    ntotal++;
    if (blog2.size() != 8 || bad_b != 0) begin
      nbad++;
      $display("FAIL auto_b_data: got size=%0d wrong=%0d expected size=8 wrong=0", blog2.size(), bad_b);
    end
    ntotal++;
    if (max_os2 != 4) begin
      nbad++;
      $display("FAIL max_outstanding: got %0d expected 4", max_os2);
    end
  endtask

  task automatic test_full_load();
    int base = wlog.size();
    int p0 = pulses1;
    int cnt;
    pulse_start();
    ntotal++;
    if (busy1 !== 1'b1 || avm1.avm_read !== 1'b1 || avm1.avm_address !== 32'd0 || err1 !== 1'b0) begin
      nbad++;
      $display("FAIL start_response: got busy=%b read=%b addr=%0d err=%b expected 1 1 0 0",
               busy1, avm1.avm_read, avm1.avm_address, err1);
    end
    wait_done1(84);
    ntotal++;
    if (done1 !== 1'b1 || busy1 !== 1'b0) begin
      nbad++;
      $display("FAIL load_latency: got done=%b busy=%b expected done=1 busy=0 within 84 cycles", done1, busy1);
    end
    for (int r = 0; r <= N; r++) begin
      cnt = row_count(base, r);
      ntotal++;
      if (cnt != 8) begin
        nbad++;
        $display("FAIL row_data_%0d: got %0d ordered elements expected 8", r, cnt);
      end
    end
    ntotal++;
    if (pulses1 - p0 != 72) begin
      nbad++;
      $display("FAIL write_pulses: got %0d expected 72", pulses1 - p0);
    end
  endtask

  task automatic test_waitrequest();
    int base = wlog.size();
    int r0 = rd2_cycles;
    int cnt;
    wait_en = 1'b1;
    pulse_start();
    ntotal++;
    if (done1 !== 1'b0 || busy1 !== 1'b1) begin
      nbad++;
      $display("FAIL restart_from_done: got done=%b busy=%b expected done=0 busy=1", done1, busy1);
    end
    wait_done1(200);
    wait_en = 1'b0;
    ntotal++;
    if (rd2_cycles - r0 != 4) begin
      nbad++;
      $display("FAIL stall_hold: got %0d cycles of read@2 expected 4", rd2_cycles - r0);
    end
    cnt = row_count(base, 2);
    ntotal++;
    if (cnt != 8 || done1 !== 1'b1) begin
      nbad++;
      $display("FAIL stall_data: got %0d ordered row-2 elements done=%b expected 8 done=1", cnt, done1);
    end
  endtask

  task automatic test_backpressure();
    int base = wlog.size();
    int p0 = pulses1;
    int leaks = 0;
    int cnt;
    pulse_start();
    for (int g = 0; g < 300 && row_count(base, 3) < 3; g++) begin
      @(posedge clk); #1;
    end
    a_full1[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_wren1[3] !== 1'b0) leaks++;
      @(posedge clk); #1;
    end
    cnt = row_count(base, 3);
    a_full1[3] = 1'b0;
    ntotal++;
    if (leaks != 0 || cnt != 3) begin
      nbad++;
      $display("FAIL full_hold: got leaks=%0d row3=%0d expected leaks=0 row3=3", leaks, cnt);
    end
    wait_done1(200);
    cnt = row_count(base, 3);
    ntotal++;
    if (cnt != 8 || pulses1 - p0 != 72 || done1 !== 1'b1) begin
      nbad++;
      $display("FAIL full_order: got row3=%0d pulses=%0d done=%b expected 8 72 1", cnt, pulses1 - p0, done1);
    end
  endtask

  task automatic test_start_ignored();
    int base = wlog.size();
    int p0 = pulses1;
    int cnt;
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    pulse_start();
    ntotal++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      nbad++;
      $display("FAIL run_start_busy: got busy=%b done=%b expected busy=1 done=0", busy1, done1);
    end
    wait_done1(200);
    cnt = row_count(base, 8);
    ntotal++;
    if (pulses1 - p0 != 72 || cnt != 8 || done1 !== 1'b1) begin
      nbad++;
      $display("FAIL run_start_ignored: got pulses=%0d b=%0d done=%b expected 72 8 1", pulses1 - p0, cnt, done1);
    end
  endtask

  task automatic test_reset_midrow();
    logic [BW+EW+N+32+13:0] out1;
    pulse_start();
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    out1 = {busy1, done1, err1, avm1.avm_read, avm1.avm_address, a_wren1, a_data1,
            b_wren1, b_data1, dbg_row1, dbg_elem1};
    ntotal++;
    if (out1 !== '0) begin
      nbad++;
      $display("FAIL midrow_reset: got %h expected 0", out1);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    ntotal++;
    if (busy1 !== 1'b0 || err1 !== 1'b0 || done1 !== 1'b0) begin
      nbad++;
      $display("FAIL post_reset_idle: got busy=%b err=%b done=%b expected 0 0 0", busy1, err1, done1);
    end
  endtask

  initial begin
    test_reset();
    test_spurious();
    test_auto_depth4();
    test_full_load();
    test_waitrequest();
    test_backpressure();
    test_start_ignored();
    test_reset_midrow();
    $display("test done: total=%0d bad=%0d", ntotal, nbad);
    $finish;
  end

endmodule
